// File: rtl/fxp_mul_pipe.sv
// Fully pipelined signed fixed-point shift-add multiplier with rounding and saturation.
// Optional sticky overflow flag is built when FXP_MUL_OVF_STICKY_EN is defined.
module fxp_mul_pipe #(
   parameter int WIIA  = 8,
   parameter int WIFA  = 8,
   parameter int WIIB  = 8,
   parameter int WIFB  = 8,
   parameter int WOI   = 8,
   parameter int WOF   = 8,
   parameter int ROUND = 1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     in_valid,
   input  logic [WIIA+WIFA-1:0]     a,
   input  logic [WIIB+WIFB-1:0]     b,
   output logic                     out_valid,
   output logic [WOI+WOF-1:0]       out,
   output logic                     overflow,
   output logic                     ovf_sticky,
   input  logic                     ovf_clr
);

   localparam int WA = WIIA + WIFA;
   localparam int WB = WIIB + WIFB;
   localparam int W  = WOI + WOF;
   localparam int WP = WA + WB;
   localparam int FP = WIFA + WIFB;
   localparam int UP = (WOF > FP) ? (WOF - FP) : 0;
   localparam int MW = WP + 1 + UP;
   localparam int CW = ((MW > W) ? MW : W) + 1;

   localparam logic [CW-1:0] POS_MAX = {{(CW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [CW-1:0] NEG_LIM = {{(CW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

   // Valid semantics: in_valid marks a pair accepted on this edge; it rides the
   // pipeline unconditionally (no stall, no backpressure) and reappears as
   // out_valid exactly WB+3 cycles later alongside its out/overflow.

   logic [WA-1:0] abs_a;
   logic [WB-1:0] abs_b;

   always_comb begin
      abs_a = a[WA-1] ? -a : a;
      abs_b = b[WB-1] ? -b : b;
   end

   logic [WA-1:0] ma_q  [0:WB-1];
   logic [WB-1:0] mb_q  [0:WB-1];
   logic [WP-1:0] acc_q [0:WB];
   logic          sg_q  [0:WB];
   logic          vl_q  [0:WB];

   // Index 0 is the operand-capture stage; index k holds the partial product after bit k-1 of |B|.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < WB; k++) begin
            ma_q[k] <= '0;
            mb_q[k] <= '0;
         end
         for (int k = 0; k <= WB; k++) begin
            acc_q[k] <= '0;
            sg_q[k]  <= 1'b0;
            vl_q[k]  <= 1'b0;
         end
      end else begin
         ma_q[0]  <= abs_a;
         mb_q[0]  <= abs_b;
         acc_q[0] <= '0;
         sg_q[0]  <= a[WA-1] ^ b[WB-1];
         vl_q[0]  <= in_valid;
         for (int k = 1; k <= WB; k++) begin
            acc_q[k] <= acc_q[k-1] + (mb_q[k-1][k-1] ? (WP'(ma_q[k-1]) << (k-1)) : '0);
            sg_q[k]  <= sg_q[k-1];
            vl_q[k]  <= vl_q[k-1];
         end
         for (int k = 1; k < WB; k++) begin
            ma_q[k] <= ma_q[k-1];
            mb_q[k] <= mb_q[k-1];
         end
      end
   end

   logic [MW-1:0] m_next;

   generate
      if (FP > WOF) begin : g_drop
         localparam int D = FP - WOF;
         logic [MW-1:0] wide;
         always_comb begin
            wide = MW'(acc_q[WB]);
            if (ROUND != 0) wide = wide + (MW'(1) << (D-1));
            m_next = wide >> D;
         end
      end else begin : g_ext
         always_comb m_next = MW'(acc_q[WB]) << UP;
      end
   endgenerate

   logic [MW-1:0] m_q;
   logic          sg_r;
   logic          vl_r;

   logic [CW-1:0] mc;
   logic [W-1:0]  neg;
   logic [W-1:0]  out_next;
   logic          ovf_next;

   // A negative result may reach exactly -2^(W-1) without saturating.
   always_comb begin
      mc       = CW'(m_q);
      neg      = -mc[W-1:0];
      out_next = '0;
      ovf_next = 1'b0;
      if (!sg_r) begin
         if (mc > POS_MAX) begin
            out_next = {1'b0, {(W-1){1'b1}}};
            ovf_next = 1'b1;
         end else begin
            out_next = mc[W-1:0];
         end
      end else begin
         if (mc > NEG_LIM) begin
            out_next = {1'b1, {(W-1){1'b0}}};
            ovf_next = 1'b1;
         end else begin
            out_next = neg;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_q       <= '0;
         sg_r      <= 1'b0;
         vl_r      <= 1'b0;
         out       <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         m_q       <= m_next;
         sg_r      <= sg_q[WB];
         vl_r      <= vl_q[WB];
         out       <= out_next;
         overflow  <= ovf_next;
         out_valid <= vl_r;
      end
   end

`ifdef FXP_MUL_OVF_STICKY_EN
   // A new overflow outranks a coincident clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_sticky <= 1'b0;
      end else if (out_valid && overflow) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky <= 1'b0;
      end
   end
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Bench for fxp_mul_pipe: a rounding and a truncating instance share stimulus and are
// checked against an integer-arithmetic reference model.
module tb_fxp_mul_pipe;

   localparam int W   = 16;
   localparam int LAT = 19;
   localparam int SH  = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic          ovf_clr = 1'b0;
   logic [15:0]   a = '0;
   logic [15:0]   b = '0;

   logic          out_valid, overflow, ovf_sticky;
   logic [W-1:0]  out;
   logic          out_valid_t, overflow_t, ovf_sticky_t;
   logic [W-1:0]  out_t;

   int checks = 0;
   int passes = 0;

   logic [W:0] exp_q[$];
   logic [W:0] exp_t_q[$];

   fxp_mul_pipe dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(out_valid), .out(out), .overflow(overflow),
      .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
   );

   fxp_mul_pipe #(.ROUND(0)) dut_t (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(out_valid_t), .out(out_t), .overflow(overflow_t),
      .ovf_sticky(ovf_sticky_t), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // Reference: exact signed product, scaled to WOF fraction bits, then saturated.
   function automatic logic [W:0] model(input logic [15:0] av, input logic [15:0] bv, input int rnd);
      longint p, mag, q, r;
      logic   ov;
      p   = longint'($signed(av)) * longint'($signed(bv));
      mag = (p < 0) ? -p : p;
      q   = (rnd != 0) ? ((mag + (longint'(1) << (SH-1))) >> SH) : (mag >> SH);
      r   = (p < 0) ? -q : q;
      ov  = 1'b0;
      if (r > 32767) begin
         r  = 32767;
         ov = 1'b1;
      end else if (r < -32768) begin
         r  = -32768;
         ov = 1'b1;
      end
      return {ov, r[15:0]};
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_wait(input logic [15:0] av, input logic [15:0] bv, output int lat);
      a = av;
      b = bv;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 4*LAT) begin
         cycle();
         lat++;
      end
   endtask

   function automatic logic [15:0] rand_b();
      logic [7:0] rb;
      if ($urandom_range(0, 1) == 1) return 16'($urandom_range(0, 65535));
      rb = 8'($urandom_range(0, 255));
      return {{8{rb[7]}}, rb};
   endfunction

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) cycle();
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
      checks++; if (out !== 16'h0000) $display("FAIL reset_out got %h want 0000", out); else passes++;
      checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passes++;
      checks++; if (ovf_sticky !== 1'b0) $display("FAIL reset_sticky got %b want 0", ovf_sticky); else passes++;
      checks++; if (out_valid_t !== 1'b0) $display("FAIL reset_out_valid_t got %b want 0", out_valid_t); else passes++;
      rstn = 1'b1;
      cycle();
   endtask

   task automatic test_directed();
      logic [15:0] ta [8];
      logic [15:0] tb [8];
      logic [15:0] tr [8];
      logic [15:0] tt [8];
      logic        tov[8];
      int          lat;
      ta[0] = 16'h0180; tb[0] = 16'h0200; tr[0] = 16'h0300; tt[0] = 16'h0300; tov[0] = 1'b0;
      ta[1] = 16'hFE80; tb[1] = 16'h0200; tr[1] = 16'hFD00; tt[1] = 16'hFD00; tov[1] = 1'b0;
      ta[2] = 16'h8000; tb[2] = 16'h0100; tr[2] = 16'h8000; tt[2] = 16'h8000; tov[2] = 1'b0;
      ta[3] = 16'h6400; tb[3] = 16'h0200; tr[3] = 16'h7FFF; tt[3] = 16'h7FFF; tov[3] = 1'b1;
      ta[4] = 16'h9C00; tb[4] = 16'h0200; tr[4] = 16'h8000; tt[4] = 16'h8000; tov[4] = 1'b1;
      ta[5] = 16'h8000; tb[5] = 16'h8000; tr[5] = 16'h7FFF; tt[5] = 16'h7FFF; tov[5] = 1'b1;
      ta[6] = 16'h0001; tb[6] = 16'h0080; tr[6] = 16'h0001; tt[6] = 16'h0000; tov[6] = 1'b0;
      ta[7] = 16'hFFFF; tb[7] = 16'h0080; tr[7] = 16'hFFFF; tt[7] = 16'h0000; tov[7] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send_wait(ta[i], tb[i], lat);
         checks++; if (lat !== LAT) $display("FAIL directed[%0d]_latency got %0d want %0d", i, lat, LAT); else passes++;
         checks++; if (out !== tr[i]) $display("FAIL directed[%0d]_out got %h want %h", i, out, tr[i]); else passes++;
         checks++; if (overflow !== tov[i]) $display("FAIL directed[%0d]_overflow got %b want %b", i, overflow, tov[i]); else passes++;
         checks++; if ({out_valid_t, out_t} !== {1'b1, tt[i]}) $display("FAIL directed[%0d]_trunc got %b/%h want 1/%h", i, out_valid_t, out_t, tt[i]); else passes++;
      end
      cycle();
   endtask

   task automatic test_back_to_back();
      int          got = 0;
      int          first = -1;
      int          last = -1;
      logic [15:0] av, bv;
      logic [W:0]  e, et;
      for (int i = 0; i < 200 && got < 50; i++) begin
         if (i < 50) begin
            av = 16'($urandom_range(0, 65535));
            bv = rand_b();
            a = av;
            b = bv;
            in_valid = 1'b1;
            exp_q.push_back(model(av, bv, 1));
            exp_t_q.push_back(model(av, bv, 0));
         end else begin
            in_valid = 1'b0;
         end
         cycle();
         if (out_valid) begin
            if (first < 0) first = i;
            last = i;
            got++;
            if (exp_q.size() > 0 && exp_t_q.size() > 0) begin
               e  = exp_q.pop_front();
               et = exp_t_q.pop_front();
               checks++; if ({overflow, out} !== e) $display("FAIL b2b_round got %b/%h want %b/%h", overflow, out, e[W], e[W-1:0]); else passes++;
               checks++; if ({out_valid_t, overflow_t, out_t} !== {1'b1, et}) $display("FAIL b2b_trunc got %b/%b/%h want 1/%b/%h", out_valid_t, overflow_t, out_t, et[W], et[W-1:0]); else passes++;
            end else begin
               checks++;
               $display("FAIL b2b_extra result got %h want none", out);
            end
         end
      end
      in_valid = 1'b0;
      checks++; if (got !== 50) $display("FAIL b2b_count got %0d want 50", got); else passes++;
      checks++; if (first !== LAT-1) $display("FAIL b2b_first got %0d want %0d", first, LAT-1); else passes++;
      checks++; if (last - first !== 49) $display("FAIL b2b_consecutive got %0d want 49", last - first); else passes++;
      exp_q.delete();
      exp_t_q.delete();
      cycle();
   endtask

   task automatic test_reset_midstream();
      int          seen = 0;
      int          lat;
      logic [15:0] av, bv;
      logic [W:0]  e;
      for (int i = 0; i < 25; i++) begin
         a = 16'($urandom_range(0, 65535));
         b = rand_b();
         in_valid = 1'b1;
         cycle();
      end
      checks++; if (out_valid !== 1'b1) $display("FAIL midrst_pre_valid got %b want 1", out_valid); else passes++;
      rstn = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else passes++;
      checks++; if ({overflow, out} !== 17'h0) $display("FAIL midrst_data got %b/%h want 0/0000", overflow, out); else passes++;
      checks++; if (out_valid_t !== 1'b0) $display("FAIL midrst_valid_t got %b want 0", out_valid_t); else passes++;
      in_valid = 1'b0;
      repeat (2) cycle();
      rstn = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (out_valid || out_valid_t) seen++;
      end
      checks++; if (seen !== 0) $display("FAIL midrst_stale got %0d want 0", seen); else passes++;
      av = 16'($urandom_range(0, 65535));
      bv = rand_b();
      e  = model(av, bv, 1);
      send_wait(av, bv, lat);
      checks++; if (lat !== LAT) $display("FAIL midrst_latency got %0d want %0d", lat, LAT); else passes++;
      checks++; if ({overflow, out} !== e) $display("FAIL midrst_result got %b/%h want %b/%h", overflow, out, e[W], e[W-1:0]); else passes++;
      cycle();
   endtask

   task automatic test_sticky();
      int lat;
`ifdef FXP_MUL_OVF_STICKY_EN
      ovf_clr = 1'b1;
      cycle();
      ovf_clr = 1'b0;
      checks++; if (ovf_sticky !== 1'b0) $display("FAIL sticky_cleared got %b want 0", ovf_sticky); else passes++;
      send_wait(16'h6400, 16'h0200, lat);
      cycle();
      checks++; if (ovf_sticky !== 1'b1) $display("FAIL sticky_set got %b want 1", ovf_sticky); else passes++;
      repeat (5) cycle();
      checks++; if (ovf_sticky !== 1'b1) $display("FAIL sticky_hold got %b want 1", ovf_sticky); else passes++;
      ovf_clr = 1'b1;
      cycle();
      ovf_clr = 1'b0;
      checks++; if (ovf_sticky !== 1'b0) $display("FAIL sticky_clear got %b want 0", ovf_sticky); else passes++;
      send_wait(16'h9C00, 16'h0200, lat);
      ovf_clr = 1'b1;
      cycle();
      ovf_clr = 1'b0;
      checks++; if (ovf_sticky !== 1'b1) $display("FAIL sticky_set_wins got %b want 1", ovf_sticky); else passes++;
      send_wait(16'h0180, 16'h0200, lat);
      cycle();
      checks++; if (ovf_sticky !== 1'b1) $display("FAIL sticky_no_ovf_hold got %b want 1", ovf_sticky); else passes++;
`else
      send_wait(16'h6400, 16'h0200, lat);
      cycle();
      checks++; if (ovf_sticky !== 1'b0) $display("FAIL sticky_off got %b want 0", ovf_sticky); else passes++;
      checks++; if (ovf_sticky_t !== 1'b0) $display("FAIL sticky_off_t got %b want 0", ovf_sticky_t); else passes++;
      ovf_clr = 1'b1;
      send_wait(16'h8000, 16'h8000, lat);
      cycle();
      ovf_clr = 1'b0;
      checks++; if (ovf_sticky !== 1'b0) $display("FAIL sticky_off_clr got %b want 0", ovf_sticky); else passes++;
`endif
      cycle();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midstream();
      test_sticky();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
